// File: rtl/mux_arbiter_if.sv
// Bundle between the mux_arbiter, its two bit-serial requesters and the
// downstream consumer of the selected result bit.
interface mux_arbiter_if;
    // Requester side: a request is consumed in the cycle its ack is high.
    logic req_a;
    logic a;
    logic ack_a;
    logic req_b;
    logic b;
    logic ack_b;
    // Ownership and select status, registered in the arbiter.
    logic grant_a;
    logic grant_b;
    logic sel;
    // Consumer side: z transfers on a cycle with z_valid & z_ready both high.
    logic z;
    logic z_valid;
    logic z_ready;

    // Arbiter view.
    modport slave (
        input  req_a, a, req_b, b, z_ready,
        output ack_a, ack_b, grant_a, grant_b, sel, z, z_valid
    );

    // Requesters/consumer view.
    modport master (
        output req_a, a, req_b, b, z_ready,
        input  ack_a, ack_b, grant_a, grant_b, sel, z, z_valid
    );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one 2:1 select datapath z = (a & ~c) | (b & c)
// between requesters A and B, with a registered single-entry result slot.
//
// Handshakes: requester x presents a bit with req_x and must hold it stable
// until ack_x; ack_x is high in exactly the cycle the bit is consumed. The
// result slot follows valid/ready: z transfers when z_valid & z_ready, and a
// new result may be written in the same cycle the old one is accepted.
module mux_arbiter #(
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    mux_arbiter_if.slave  bus_io,
    output logic [1:0]    dbg_state_o
);
    localparam int CNT_W = $clog2(BURST + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_b_q, last_b_d;   // 1: B was granted most recently
    logic [CNT_W-1:0]   cnt_q, cnt_d;         // beats taken in the current grant
    logic               grant_a_q, grant_b_q;
    logic               z_q, z_valid_q;

    logic               slot_free;
    logic               ack_a, ack_b, beat;
    logic               last_beat;
    logic               z_d;

    // A beat may be written when the slot is empty or being drained now.
    assign slot_free = !z_valid_q || bus_io.z_ready;
    assign ack_a     = grant_a_q & bus_io.req_a & slot_free;
    assign ack_b     = grant_b_q & bus_io.req_b & slot_free;
    assign beat      = ack_a | ack_b;
    assign last_beat = (cnt_q == CNT_W'(BURST - 1));

    // The single shared select datapath; the select is the registered grant_b.
    assign z_d = (bus_io.a & ~grant_b_q) | (bus_io.b & grant_b_q);

    // Next-state arbitration: round-robin on ties, burst limit, handover.
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus_io.req_a && (!bus_io.req_b || last_b_q)) begin
                    state_d  = GRANT_A;
                    last_b_d = 1'b0;
                    cnt_d    = '0;
                end else if (bus_io.req_b) begin
                    state_d  = GRANT_B;
                    last_b_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            GRANT_A: begin
                if (!bus_io.req_a || (ack_a && last_beat)) begin
                    // Release: hand over if B waits, else restart A or idle.
                    cnt_d = '0;
                    if (bus_io.req_b) begin
                        state_d  = GRANT_B;
                        last_b_d = 1'b1;
                    end else if (!bus_io.req_a) begin
                        state_d = IDLE;
                    end
                end else if (ack_a) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GRANT_B: begin
                if (!bus_io.req_b || (ack_b && last_beat)) begin
                    cnt_d = '0;
                    if (bus_io.req_a) begin
                        state_d  = GRANT_A;
                        last_b_d = 1'b0;
                    end else if (!bus_io.req_b) begin
                        state_d = IDLE;
                    end
                end else if (ack_b) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, registered grant/select decode and the result slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            cnt_q     <= '0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            z_q       <= 1'b0;
            z_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            cnt_q     <= cnt_d;
            grant_a_q <= (state_d == GRANT_A);
            grant_b_q <= (state_d == GRANT_B);
            if (beat) begin
                z_q       <= z_d;
                z_valid_q <= 1'b1;
            end else if (bus_io.z_ready) begin
                z_valid_q <= 1'b0;
            end
        end
    end

    assign bus_io.ack_a   = ack_a;
    assign bus_io.ack_b   = ack_b;
    assign bus_io.grant_a = grant_a_q;
    assign bus_io.grant_b = grant_b_q;
    assign bus_io.sel     = grant_b_q;
    assign bus_io.z       = z_q;
    assign bus_io.z_valid = z_valid_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed stimulus, a cycle model of the arbitration
// rules compared on every cycle, and literal expectations for key moments.
module tb_mux_arbiter;
    localparam int BURST = 4;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;

    mux_arbiter_if bus ();

    mux_arbiter #(.BURST(BURST)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_io      (bus),
        .dbg_state_o (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counters and check helper ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 nobody, 1 A, 2 B. used: beats taken in the current grant.
    typedef struct packed {
        logic [1:0] owner;
        logic [7:0] used;
        logic [1:0] last;
        logic       z;
        logic       zv;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(input mstate_t s, input logic ra,
                                           input logic av, input logic rb,
                                           input logic bv, input logic rdy);
        mstate_t n;
        logic    slot, take_a, take_b, mine, theirs;
        n      = s;
        slot   = !s.zv || rdy;
        take_a = (s.owner == 2'd1) && ra && slot;
        take_b = (s.owner == 2'd2) && rb && slot;
        if (take_a || take_b) begin
            n.z    = take_a ? av : bv;
            n.zv   = 1'b1;
            n.used = s.used + 8'd1;
        end else if (rdy) begin
            n.zv = 1'b0;
        end
        if (s.owner == 2'd0) begin
            if (ra && (!rb || s.last == 2'd2)) begin
                n.owner = 2'd1; n.last = 2'd1; n.used = 8'd0;
            end else if (rb) begin
                n.owner = 2'd2; n.last = 2'd2; n.used = 8'd0;
            end
        end else begin
            mine   = (s.owner == 2'd1) ? ra : rb;
            theirs = (s.owner == 2'd1) ? rb : ra;
            if (!mine || n.used == 8'(BURST)) begin
                n.used = 8'd0;
                if (theirs) begin
                    n.owner = 2'd3 - s.owner;
                    n.last  = n.owner;
                end else if (!mine) begin
                    n.owner = 2'd0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m <= '{owner: 2'd0, used: 8'd0, last: 2'd2, z: 1'b0, zv: 1'b0};
        end else begin
            m <= model_next(m, bus.req_a, bus.a, bus.req_b, bus.b, bus.z_ready);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check1("cmp_grant_a", bus.grant_a, m.owner == 2'd1);
        check1("cmp_grant_b", bus.grant_b, m.owner == 2'd2);
        check1("cmp_sel",     bus.sel,     m.owner == 2'd2);
        check1("cmp_ack_a",   bus.ack_a,
               (m.owner == 2'd1) && bus.req_a && (!m.zv || bus.z_ready));
        check1("cmp_ack_b",   bus.ack_b,
               (m.owner == 2'd2) && bus.req_b && (!m.zv || bus.z_ready));
        check1("cmp_z",       bus.z,       m.z);
        check1("cmp_z_valid", bus.z_valid, m.zv);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard queue ----------------
    logic [1:0] exp_q[$];   // expected {ack_b, ack_a} per cycle

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] e;
        reset       = 1'b1;
        bus.req_a   = 1'b1;
        bus.req_b   = 1'b1;
        bus.a       = 1'b1;
        bus.b       = 1'b0;
        bus.z_ready = 1'b1;

        // Reset with both requesting: everything quiet.
        step(2);
        check1("rst_z",       bus.z,       1'b0);
        check1("rst_z_valid", bus.z_valid, 1'b0);
        check1("rst_sel",     bus.sel,     1'b0);
        check1("rst_grant_a", bus.grant_a, 1'b0);
        check1("rst_grant_b", bus.grant_b, 1'b0);
        check1("rst_ack_a",   bus.ack_a,   1'b0);
        check1("rst_ack_b",   bus.ack_b,   1'b0);
        check1("rst_state",   dbg_state == 2'd0, 1'b1);

        // Fairness: A first, 4 A beats, 4 B beats, repeating, no gaps.
        for (int i = 0; i < 16; i++) exp_q.push_back(((i / 4) % 2 == 0) ? 2'b01 : 2'b10);
        reset = 1'b0;
        while (exp_q.size() > 0) begin
            step(1);
            e = exp_q.pop_front();
            check1("fair_ack_a", bus.ack_a, e[0]);
            check1("fair_ack_b", bus.ack_b, e[1]);
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        step(1);

        // Single requester A, a=1 then a=0.
        bus.req_a = 1'b1;
        bus.a     = 1'b1;
        step(1);
        check1("a_grant",   bus.grant_a, 1'b1);
        check1("a_sel",     bus.sel,     1'b0);
        check1("a_ack",     bus.ack_a,   1'b1);
        check1("a_zv_lat",  bus.z_valid, 1'b0);
        step(1);
        check1("a_z1",      bus.z,       1'b1);
        check1("a_zv1",     bus.z_valid, 1'b1);
        bus.a = 1'b0;
        step(1);
        check1("a_z0",      bus.z,       1'b0);
        bus.req_a = 1'b0;
        step(1);
        check1("a_release", bus.grant_a, 1'b0);
        check1("a_drained", bus.z_valid, 1'b0);

        // Mux truth table through B with a held at 1.
        bus.a     = 1'b1;
        bus.b     = 1'b0;
        bus.req_b = 1'b1;
        step(1);
        check1("b_grant", bus.grant_b, 1'b1);
        check1("b_sel",   bus.sel,     1'b1);
        check1("b_ack",   bus.ack_b,   1'b1);
        step(1);
        check1("b_z0",    bus.z,       1'b0);
        bus.b = 1'b1;
        step(1);
        check1("b_z1",    bus.z,       1'b1);
        bus.req_b = 1'b0;
        step(1);
        check1("b_release", bus.grant_b, 1'b0);

        // Backpressure on A.
        bus.req_a   = 1'b1;
        bus.a       = 1'b1;
        bus.z_ready = 1'b0;
        step(1);
        check1("bp_first_ack", bus.ack_a, 1'b1);
        step(1);
        for (int i = 0; i < 3; i++) begin
            check1("bp_no_ack",  bus.ack_a,   1'b0);
            check1("bp_z_held",  bus.z,       1'b1);
            check1("bp_zv_held", bus.z_valid, 1'b1);
            step(1);
        end
        bus.z_ready = 1'b1;
        #1;
        check1("bp_resume_ack", bus.ack_a, 1'b1);
        bus.req_b = 1'b1;
        bus.b     = 1'b0;
        step(1);
        check1("bp_beat3_a", bus.ack_a, 1'b1);
        check1("bp_beat3_b", bus.ack_b, 1'b0);
        step(1);
        check1("bp_beat4_a", bus.ack_a, 1'b1);
        step(1);
        check1("bp_hand_gb", bus.grant_b, 1'b1);
        check1("bp_hand_ab", bus.ack_b,   1'b1);
        check1("bp_hand_aa", bus.ack_a,   1'b0);

        // Reset mid-burst after two A beats.
        bus.req_b = 1'b0;
        bus.req_a = 1'b1;
        bus.a     = 1'b1;
        step(3);
        check1("mid_zv_before", bus.z_valid, 1'b1);
        reset = 1'b1;
        #1;
        check1("mid_grant_a", bus.grant_a, 1'b0);
        check1("mid_sel",     bus.sel,     1'b0);
        check1("mid_ack_a",   bus.ack_a,   1'b0);
        check1("mid_z",       bus.z,       1'b0);
        check1("mid_zv",      bus.z_valid, 1'b0);
        step(1);
        reset     = 1'b0;
        bus.req_a = 1'b0;
        bus.req_b = 1'b1;
        bus.b     = 1'b1;
        step(1);
        check1("post_rst_grant_b", bus.grant_b, 1'b1);
        check1("post_rst_sel",     bus.sel,     1'b1);
        bus.req_b = 1'b0;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that shares the single-bit 2:1 select datapath z = (a & ~c) | (b & c) between two requesters, A and B. It drives the select line (c), steps each granted requester's data bits through the datapath, and presents the result on a registered valid/ready output. The block sits between two bit-serial sources and one downstream consumer. It owns the only instance of the select datapath.

## Interface
- BURST, 4: maximum beats per grant before the arbiter must re-arbitrate; legal range 1..255.
- CNT_W, $clog2(BURST+1): width of the beat counter; derived, not overridden.

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_a  input  1  requester A has a data bit on a
- a  input  1  requester A data bit
- ack_a  output  1  A's bit consumed this cycle
- req_b  input  1  requester B has a data bit on b
- b  input  1  requester B data bit
- ack_b  output  1  B's bit consumed this cycle
- grant_a  output  1  A currently owns the datapath
- grant_b  output  1  B currently owns the datapath
- sel  output  1  datapath select (c): 0 selects a, 1 selects b
- z  output  1  registered datapath result
- z_valid  output  1  z holds an unconsumed result
- z_ready  input  1  consumer accepts z this cycle

## Operation
- FSM states: IDLE, GRANT_A, GRANT_B. The state register also holds last_served (A/B) and beat_cnt[CNT_W-1:0].
- grant_a = (state==GRANT_A), grant_b = (state==GRANT_B), and sel = grant_b. All are registered and decoded from state.
- slot_free = !z_valid | z_ready.
- ack_a = grant_a & req_a & slot_free, and ack_b = grant_b & req_b & slot_free. Both are combinational.
- A beat happens when ack_x=1. On a beat, z <= (a & ~sel) | (b & sel), z_valid <= 1, and beat_cnt++.
- If z_ready=1 and there is no beat, z_valid <= 0. z holds its value whenever there is no beat.
- IDLE transitions:
  - Only req_a: go to GRANT_A.
  - Only req_b: go to GRANT_B.
  - Both: grant the requester that is not last_served.
  - Neither: stay in IDLE.
  - Entering a grant sets last_served to that requester and clears beat_cnt.
- GRANT_x when req_x=0: release.
- GRANT_x on a beat with beat_cnt==BURST-1: release.
- Release rule: go to the other grant state if the other requester's req is high. Otherwise re-enter GRANT_x with beat_cnt=0 if req_x is high, else go to IDLE.
- GRANT_x when req_x=1 but slot_free=0: hold. No beat happens and beat_cnt is unchanged.
- The datapath is purely combinational inside the block. Requesters must hold a/b stable while req is high and unacked.
- Reset values:
  - state=IDLE, last_served=B (so A wins the first tie), beat_cnt=0.
  - z=0, z_valid=0, sel=0, grant_a=0, grant_b=0, ack_a=0, ack_b=0.

## Timing
- Request latency:
  - req_x rises in cycle n while in IDLE: grant_x=1 in cycle n+1.
  - First ack_x is possible in cycle n+1.
  - z/z_valid update at the edge ending n+1 and are visible in n+2.
- Throughput: one beat per cycle while z_ready is held high.
- Handover from GRANT_A to GRANT_B takes 0 idle cycles. The last A beat lands in cycle k and B's first beat can land in cycle k+1. sel changes together with grant.
- Backpressure: while z_valid=1 and z_ready=0, no ack is issued and z, z_valid and beat_cnt are frozen.
- Simultaneous z_ready and beat: the new result replaces the old one and z_valid stays 1.
- Reset asserted mid-burst: all outputs take their reset values immediately (asynchronously). Any in-flight z is discarded and no ack is issued while reset is high.
- First cycle after reset deassertion: the FSM samples req_a/req_b exactly as in IDLE.

## Test plan
- Reset check: assert reset with req_a=req_b=1 -> z=0, z_valid=0, sel=0, grants=0 and acks=0 while reset is high.
- Single requester A:
  - Stimulus: req_a=1, a=1, z_ready=1.
  - Expected: grant_a the next cycle, sel=0, then z=1 and z_valid=1 the cycle after.
  - Next, drive a=0 -> z=0 after one more cycle.
- Fairness: req_a=req_b=1 continuously, BURST=4, z_ready=1 -> ack pattern is 4 A beats then 4 B beats, repeating, with no gap cycles. A goes first.
- Mux truth table through B:
  - Stimulus: req_b=1, b=0 then b=1, with a held at 1.
  - Expected: sel=1 and z follows b (0, then 1), never a.
- Backpressure: z_valid=1, z_ready=0 for 3 cycles -> ack_a=0, z frozen, beat_cnt unchanged. Raising z_ready resumes with one beat that same cycle.
- Reset mid-burst: assert reset after 2 A beats -> immediate return to reset values. After release with only req_b=1 -> grant_b the next cycle.
